// File: rtl/i2c_bit_sequencer_if.sv
// ============================================================================
// Module   : i2c_bit_sequencer_if
// Purpose  : SCL/START/STOP event inputs and per-byte strobes of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface i2c_bit_sequencer_if;
   logic       scl_rise;
   logic       scl_fall;
   logic       start;
   logic       stop;
   logic       rx_shift;
   logic       tx_shift;
   logic       byte_received;
   logic       ack_prep;
   logic       ack_check;
   logic       ack_done;
   logic [3:0] bit_count;
   logic       active;

   modport master (
      output scl_rise, scl_fall, start, stop,
      input  rx_shift, tx_shift, byte_received, ack_prep, ack_check, ack_done,
      input  bit_count, active
   );

   modport slave (
      input  scl_rise, scl_fall, start, stop,
      output rx_shift, tx_shift, byte_received, ack_prep, ack_check, ack_done,
      output bit_count, active
   );
endinterface

`default_nettype wire

// File: rtl/i2c_bit_sequencer.sv
// ============================================================================
// Module   : i2c_bit_sequencer
// Purpose  : Counts SCL edges after START and emits per-byte shift/ACK strobes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_bit_sequencer #(
   parameter int BITS = 8
) (
   input  wire                   clk,
   input  wire                   rst,
   i2c_bit_sequencer_if.slave    bus_io
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_DATA     = 3'd1;
   localparam logic [2:0] S_ACK_FALL = 3'd2;
   localparam logic [2:0] S_ACK_RISE = 3'd3;
   localparam logic [2:0] S_ACK_END  = 3'd4;

   localparam logic [3:0] C_BITS = 4'(BITS);

   logic [2:0] state_q, state_d;
   logic [3:0] count_q, count_d;
   logic       active_q, active_d;
   logic       rx_shift_q, rx_shift_d;
   logic       tx_shift_q, tx_shift_d;
   logic       byte_rx_q, byte_rx_d;
   logic       ack_prep_q, ack_prep_d;
   logic       ack_check_q, ack_check_d;
   logic       ack_done_q, ack_done_d;

   logic       rise_only;
   logic       fall_only;
   logic [3:0] count_inc;

   // A rise and fall in the same cycle cancel each other out.
   assign rise_only = bus_io.scl_rise & ~bus_io.scl_fall;
   assign fall_only = bus_io.scl_fall & ~bus_io.scl_rise;
   assign count_inc = count_q + 4'd1;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      rx_shift_d  = 1'b0;
      tx_shift_d  = 1'b0;
      byte_rx_d   = 1'b0;
      ack_prep_d  = 1'b0;
      ack_check_d = 1'b0;
      ack_done_d  = 1'b0;

      if (bus_io.stop) begin
         state_d = S_IDLE;
         count_d = 4'd0;
      end else if (bus_io.start) begin
         state_d = S_DATA;
         count_d = 4'd0;
      end else begin
         case (state_q)
            S_DATA: begin
               if (rise_only) begin
                  count_d    = count_inc;
                  rx_shift_d = 1'b1;
                  if (count_inc == C_BITS) begin
                     byte_rx_d = 1'b1;
                     state_d   = S_ACK_FALL;
                  end
               end else if (fall_only && count_q != 4'd0) begin
                  tx_shift_d = 1'b1;
               end
            end
            S_ACK_FALL: begin
               if (fall_only) begin
                  ack_prep_d = 1'b1;
                  state_d    = S_ACK_RISE;
               end
            end
            S_ACK_RISE: begin
               if (rise_only) begin
                  ack_check_d = 1'b1;
                  state_d     = S_ACK_END;
               end
            end
            S_ACK_END: begin
               if (fall_only) begin
                  ack_done_d = 1'b1;
                  count_d    = 4'd0;
                  state_d    = S_DATA;
               end
            end
            default: begin
               state_d = S_IDLE;
               count_d = 4'd0;
            end
         endcase
      end

      active_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         count_q     <= 4'd0;
         active_q    <= 1'b0;
         rx_shift_q  <= 1'b0;
         tx_shift_q  <= 1'b0;
         byte_rx_q   <= 1'b0;
         ack_prep_q  <= 1'b0;
         ack_check_q <= 1'b0;
         ack_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         active_q    <= active_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         byte_rx_q   <= byte_rx_d;
         ack_prep_q  <= ack_prep_d;
         ack_check_q <= ack_check_d;
         ack_done_q  <= ack_done_d;
      end
   end

   assign bus_io.rx_shift      = rx_shift_q;
   assign bus_io.tx_shift      = tx_shift_q;
   assign bus_io.byte_received = byte_rx_q;
   assign bus_io.ack_prep      = ack_prep_q;
   assign bus_io.ack_check     = ack_check_q;
   assign bus_io.ack_done      = ack_done_q;
   assign bus_io.bit_count     = count_q;
   assign bus_io.active        = active_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_bit_sequencer.sv
// ============================================================================
// Module   : tb_i2c_bit_sequencer
// Purpose  : Directed and random stimulus against an edge-sequence model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_bit_sequencer;
   localparam int BITS = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   i2c_bit_sequencer_if bus ();

   i2c_bit_sequencer #(.BITS(BITS)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   always #5 clk = ~clk;

   // model: rises seen in byte, and position inside the ACK slot (0 = data)
   bit m_active;
   int m_rises;
   int m_ack;
   bit e_rx, e_tx, e_br, e_prep, e_chk, e_done;

   int  n_rx, n_tx, n_br, n_prep, n_chk, n_done, n_inactive;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      bit r, f;
      r = bus.scl_rise;
      f = bus.scl_fall;
      {e_rx, e_tx, e_br, e_prep, e_chk, e_done} = '0;
      if (rst) begin
         m_active = 0; m_rises = 0; m_ack = 0;
      end else if (bus.stop) begin
         m_active = 0; m_rises = 0; m_ack = 0;
      end else if (bus.start) begin
         m_active = 1; m_rises = 0; m_ack = 0;
      end else if (m_active && !(r && f)) begin
         if (m_ack == 0) begin
            if (r) begin
               m_rises++;
               e_rx = 1;
               if (m_rises == BITS) begin e_br = 1; m_ack = 1; end
            end else if (f && m_rises >= 1) begin
               e_tx = 1;
            end
         end else if (m_ack == 1 && f) begin e_prep = 1; m_ack = 2; end
         else if (m_ack == 2 && r) begin e_chk = 1; m_ack = 3; end
         else if (m_ack == 3 && f) begin e_done = 1; m_ack = 0; m_rises = 0; end
      end
      #1;
      check("rx_shift",      int'(bus.rx_shift),      int'(e_rx));
      check("tx_shift",      int'(bus.tx_shift),      int'(e_tx));
      check("byte_received", int'(bus.byte_received), int'(e_br));
      check("ack_prep",      int'(bus.ack_prep),      int'(e_prep));
      check("ack_check",     int'(bus.ack_check),     int'(e_chk));
      check("ack_done",      int'(bus.ack_done),      int'(e_done));
      check("bit_count",     int'(bus.bit_count),     m_rises);
      check("active",        int'(bus.active),        int'(m_active));
      n_rx   += int'(bus.rx_shift);
      n_tx   += int'(bus.tx_shift);
      n_br   += int'(bus.byte_received);
      n_prep += int'(bus.ack_prep);
      n_chk  += int'(bus.ack_check);
      n_done += int'(bus.ack_done);
      n_inactive += int'(!bus.active);
   end

   task automatic clr_counts();
      n_rx = 0; n_tx = 0; n_br = 0; n_prep = 0; n_chk = 0; n_done = 0; n_inactive = 0;
   endtask

   // one-cycle event pulse followed by a quiet cycle; outputs valid on return
   task automatic cyc(input bit r, input bit f, input bit s, input bit p);
      @(negedge clk);
      bus.scl_rise = r; bus.scl_fall = f; bus.start = s; bus.stop = p;
      @(negedge clk);
      bus.scl_rise = 0; bus.scl_fall = 0; bus.start = 0; bus.stop = 0;
   endtask

   task automatic pairs(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(1, 0, 0, 0);
         cyc(0, 1, 0, 0);
      end
   endtask

   task automatic full_byte();
      pairs(BITS);
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);
   endtask

   initial begin
      bus.scl_rise = 0; bus.scl_fall = 0; bus.start = 0; bus.stop = 0;
      clr_counts();

      // reset with edges toggling
      rst = 1;
      @(negedge clk); bus.scl_rise = 1; bus.start = 1;
      @(negedge clk); bus.scl_rise = 0; bus.scl_fall = 1; bus.start = 0;
      @(negedge clk); bus.scl_fall = 0; rst = 0;
      check("reset bit_count", int'(bus.bit_count), 0);
      check("reset active", int'(bus.active), 0);
      check("reset strobes", int'({bus.rx_shift, bus.tx_shift, bus.byte_received,
                                   bus.ack_prep, bus.ack_check, bus.ack_done}), 0);

      // full byte, checking the 8th rise and the ACK closure explicitly
      cyc(0, 0, 1, 0);
      clr_counts();
      cyc(0, 1, 0, 0);
      pairs(BITS - 1);
      cyc(1, 0, 0, 0);
      check("byte8 br+rx", int'({bus.byte_received, bus.rx_shift}), 3);
      check("byte8 count", int'(bus.bit_count), 8);
      cyc(0, 1, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);
      check("ack_done count", int'(bus.bit_count), 0);
      check("byte1 rx", n_rx, 8);
      check("byte1 tx", n_tx, 7);
      check("byte1 ack pattern", n_br * 1000 + n_prep * 100 + n_chk * 10 + n_done, 1111);

      // second byte without STOP
      clr_counts();
      full_byte();
      check("byte2 rx", n_rx, 8);
      check("byte2 tx", n_tx, 7);
      check("byte2 ack pattern", n_br * 1000 + n_prep * 100 + n_chk * 10 + n_done, 1111);
      check("byte2 active held", n_inactive, 0);

      // STOP mid-byte
      clr_counts();
      pairs(3);
      cyc(0, 0, 0, 1);
      check("stop active", int'(bus.active), 0);
      check("stop count", int'(bus.bit_count), 0);
      pairs(BITS + 1);
      check("stop no rx after", n_rx, 3);
      check("stop no ack", n_br + n_prep + n_chk + n_done, 0);

      // repeated START inside ACK_RISE
      cyc(0, 0, 1, 0);
      cyc(0, 1, 0, 0);
      pairs(BITS);
      clr_counts();
      cyc(0, 0, 1, 0);
      check("rstart count", int'(bus.bit_count), 0);
      pairs(BITS);
      check("rstart no ack_check", n_chk, 0);
      check("rstart byte_received", n_br, 1);
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);

      // simultaneous edges, then START+STOP together
      cyc(0, 0, 1, 0);
      cyc(0, 1, 0, 0);
      pairs(4);
      clr_counts();
      cyc(1, 1, 0, 0);
      check("simul count", int'(bus.bit_count), 4);
      check("simul strobes", n_rx + n_tx + n_br + n_prep + n_chk + n_done, 0);
      cyc(0, 0, 1, 1);
      check("start+stop active", int'(bus.active), 0);

      // back-to-back edges with no gap
      cyc(0, 0, 1, 0);
      clr_counts();
      for (int i = 0; i < 2 * (BITS + 1); i++) begin
         @(negedge clk);
         bus.scl_rise = (i % 2 == 0);
         bus.scl_fall = (i % 2 == 1);
      end
      @(negedge clk); bus.scl_rise = 0; bus.scl_fall = 0;
      @(negedge clk);
      check("b2b rx", n_rx, 8);
      check("b2b done", n_done, 1);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         rst          = ($urandom_range(0, 299) == 0);
         bus.start    = ($urandom_range(0, 59) == 0);
         bus.stop     = ($urandom_range(0, 99) == 0);
         bus.scl_rise = ($urandom_range(0, 2) == 0);
         bus.scl_fall = ($urandom_range(0, 2) == 0);
      end
      @(negedge clk);
      rst = 0; bus.start = 0; bus.stop = 0; bus.scl_rise = 0; bus.scl_fall = 0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/i2c_bit_sequencer.md
# i2c_bit_sequencer

Bit-level sequencer for the I2C slave datapath. It counts synchronized SCL edges after a START and produces the per-byte strobes that the main slave controller waits on: `byte_received`, `ack_prep`, `ack_check` and `ack_done`. It also produces the shift strobes for the RX and TX shift registers. It sits between the SCL/SDA edge detectors and the main controller FSM, and it owns no data.

## Interface
Parameters:
- `BITS`, default 8: data bits per byte before the ACK slot (legal range 2-15).

Ports:
- `clk`, in, 1: system clock. The block has one clock.
- `rst`, in, 1: reset. Synchronous and active-high.
- `scl_rise`, in, 1: one-cycle pulse on a synchronized SCL rising edge.
- `scl_fall`, in, 1: one-cycle pulse on a synchronized SCL falling edge.
- `start`, in, 1: one-cycle pulse on a START or repeated START.
- `stop`, in, 1: one-cycle pulse on a STOP.
- `rx_shift`, out, 1: pulse telling the RX shift register to sample SDA (a data-bit rising edge).
- `tx_shift`, out, 1: pulse telling the TX shift register to advance to the next bit (a data-bit falling edge).
- `byte_received`, out, 1: pulse after the last data-bit rising edge.
- `ack_prep`, out, 1: pulse on the falling edge that opens the ACK slot.
- `ack_check`, out, 1: pulse on the ACK-slot rising edge, when SDA holds the master's ACK/NACK.
- `ack_done`, out, 1: pulse on the falling edge that closes the ACK slot.
- `bit_count`, out, 4: number of data rising edges seen in the current byte (0..BITS).
- `active`, out, 1: high from START until STOP.

## Operation
- States: IDLE, DATA, ACK_FALL, ACK_RISE, ACK_END.
- Event priority each cycle, highest first: `rst`, then `stop`, then `start`, then the SCL edges.
- If `scl_rise` and `scl_fall` arrive in the same cycle, both are ignored: state and count are held and no strobe is produced.
- IDLE:
  - `active`=0. SCL edges are ignored.
  - `start` → DATA with `bit_count`=0.
- DATA:
  - `scl_rise` → `bit_count`+1 and `rx_shift` pulses.
  - If that rise makes the count equal BITS, `byte_received` also pulses and the state goes to ACK_FALL.
  - `scl_fall` while 1 ≤ `bit_count` ≤ BITS-1 → `tx_shift` pulses.
  - `scl_fall` while `bit_count`=0 (the START-to-first-bit fall) produces no strobe.
- ACK_FALL: `scl_fall` → `ack_prep` pulses, state goes to ACK_RISE.
- ACK_RISE: `scl_rise` → `ack_check` pulses, state goes to ACK_END.
- ACK_END: `scl_fall` → `ack_done` pulses, `bit_count` goes to 0, state goes to DATA for the next byte.
- An edge whose direction is unexpected in the ACK states (a rise in ACK_FALL or ACK_END, a fall in ACK_RISE) is ignored.
- `stop` in any state → IDLE, `bit_count`=0, and no strobe that cycle.
- `start` in any non-IDLE state (repeated START) → DATA, `bit_count`=0, and any byte in progress is discarded without strobes.
- The strobes are mutually exclusive: at most one of `rx_shift`, `tx_shift`, `ack_prep`, `ack_check`, `ack_done` is high in any cycle. The one exception is that `byte_received` coincides with the final `rx_shift`.

## Timing
- All outputs are registered.
- Reset values: `rx_shift`, `tx_shift`, `byte_received`, `ack_prep`, `ack_check` and `ack_done` = 0; `bit_count`=0; `active`=0; state = IDLE.
- Latency: a strobe is high for exactly one cycle, in the cycle after its qualifying input pulse.
- `bit_count` and `active` update in that same cycle.
- `rst` high during a byte: the state is IDLE from the next edge of `clk`. Edges and START arriving while `rst` is high are lost.
- Minimum spacing between edge pulses is 1 cycle; back-to-back edge pulses must each be processed.
- `bit_count` never exceeds BITS and never wraps.
- There is no timeout: the block waits indefinitely in any state, so clock stretching by the controller is transparent.

## Test plan
- Reset: hold `rst` for 2 cycles with edges toggling → every output 0 and `bit_count`=0.
- Full byte (BITS=8): `start`, then one fall followed by 8 rise/fall pairs.
  - Required: 8 `rx_shift` and 7 `tx_shift` pulses.
  - `byte_received` coincides with the 8th `rx_shift`, and `bit_count`=8.
  - The 8th fall gives `ack_prep`, the 9th rise gives `ack_check`, the 9th fall gives `ack_done` and `bit_count`=0.
- Two consecutive bytes without STOP: the second byte repeats the same 8/7/1/1/1/1 strobe pattern; `active` stays 1 throughout.
- STOP mid-byte: `stop` after 3 rises → IDLE, `active`=0, and no `byte_received` or ACK strobes. Later edges without `start` produce nothing.
- Repeated START in ACK_RISE: `start` → `bit_count`=0 and no `ack_check`. The next 8 rises give `byte_received`.
- Simultaneous `scl_rise` and `scl_fall` in DATA with `bit_count`=4: `bit_count` stays 4 and no strobe fires. Also, `start` and `stop` in the same cycle → IDLE.
